// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and constants for the multiply/divide controller.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    localparam logic [31:0] MDU_DZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        DZ
    } mdu_state_e;

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negation; used both for operand magnitudes and result sign fix-up.
module mdu_abs_neg (
    input  logic [31:0] value,
    input  logic        en,
    output logic [31:0] result
);

    assign result = en ? (~value + 32'd1) : value;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences the multiplier pipeline and the
// external iterative divider, and stalls HI/LO reads while a result is pending.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic        i_flush,
    input  logic        i_mfhi_req,
    input  logic        i_mflo_req,
    output logic        o_busy,
    output logic        o_read_stall,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_mul_start,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    output logic        o_mul_neg,
    input  logic [31:0] i_mul_hi,
    input  logic [31:0] i_mul_lo,
    output logic        o_div_start,
    output logic        o_div_abort,
    output logic [31:0] o_div_dividend,
    output logic [31:0] o_div_divisor,
    input  logic        i_div_done,
    input  logic [31:0] i_div_quot,
    input  logic [31:0] i_div_rem
);

    mdu_state_e  state;
    logic [7:0]  count;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] dz_hi;

    logic        op_signed;
    logic        accept;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // MULT and DIV are the even codes; the bit is meaningless for MTHI/MTLO.
    assign op_signed    = ~i_op[0];
    assign accept       = i_op_valid & (state == IDLE) & ~i_flush;
    assign o_busy       = (state != IDLE);
    assign o_read_stall = (i_mfhi_req | i_mflo_req) & o_busy;

    mdu_abs_neg u_rs_mag (
        .value  (i_rs_data),
        .en     (op_signed & i_rs_data[31]),
        .result (rs_mag)
    );

    mdu_abs_neg u_rt_mag (
        .value  (i_rt_data),
        .en     (op_signed & i_rt_data[31]),
        .result (rt_mag)
    );

    mdu_abs_neg u_quot_fix (
        .value  (i_div_quot),
        .en     (q_neg),
        .result (quot_fix)
    );

    mdu_abs_neg u_rem_fix (
        .value  (i_div_rem),
        .en     (r_neg),
        .result (rem_fix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= 8'd0;
            q_neg          <= 1'b0;
            r_neg          <= 1'b0;
            dz_hi          <= 32'd0;
            o_hi           <= 32'd0;
            o_lo           <= 32'd0;
            o_mul_start    <= 1'b0;
            o_mul_a        <= 32'd0;
            o_mul_b        <= 32'd0;
            o_mul_neg      <= 1'b0;
            o_div_start    <= 1'b0;
            o_div_abort    <= 1'b0;
            o_div_dividend <= 32'd0;
            o_div_divisor  <= 32'd0;
        end else begin
            o_mul_start <= 1'b0;
            o_div_start <= 1'b0;
            o_div_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (i_op)
                            MDU_MULT, MDU_MULTU: begin
                                o_mul_a     <= rs_mag;
                                o_mul_b     <= rt_mag;
                                o_mul_neg   <= op_signed & (i_rs_data[31] ^ i_rt_data[31]);
                                o_mul_start <= 1'b1;
                                count       <= 8'(MULT_LATENCY);
                                state       <= MUL_WAIT;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                if (i_rt_data == 32'd0) begin
                                    dz_hi <= i_rs_data;
                                    state <= DZ;
                                end else begin
                                    o_div_dividend <= rs_mag;
                                    o_div_divisor  <= rt_mag;
                                    q_neg          <= op_signed & (i_rs_data[31] ^ i_rt_data[31]);
                                    r_neg          <= op_signed & i_rs_data[31];
                                    o_div_start    <= 1'b1;
                                    state          <= DIV_WAIT;
                                end
                            end
                            MDU_MTHI: o_hi <= i_rs_data;
                            MDU_MTLO: o_lo <= i_rs_data;
                            default: ;
                        endcase
                    end
                end
                MUL_WAIT: begin
                    if (i_flush) begin
                        count <= 8'd0;
                        state <= IDLE;
                    end else begin
                        count <= count - 8'd1;
                        if (count == 8'd1) begin
                            o_hi  <= i_mul_hi;
                            o_lo  <= i_mul_lo;
                            state <= IDLE;
                        end
                    end
                end
                DIV_WAIT: begin
                    // A done pulse coinciding with a flush belongs to a killed op.
                    if (i_flush) begin
                        o_div_abort <= 1'b1;
                        state       <= IDLE;
                    end else if (i_div_done) begin
                        o_lo  <= quot_fix;
                        o_hi  <= rem_fix;
                        state <= IDLE;
                    end
                end
                DZ: begin
                    if (!i_flush) begin
                        o_hi <= dz_hi;
                        o_lo <= MDU_DZ_LO;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the Yttrium core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and owns the architectural HI/LO registers. It sequences the two-stage sign-magnitude multiplier pipeline (partial-product stage plus final-add/negate stage) and an external iterative divider. It also raises a stall toward the pipeline when MFHI/MFLO would read HI/LO before a pending result lands.

## Interface
- MULT_LATENCY, 2: cycles from `o_mul_start` (inclusive) until the multiplier result at `i_mul_hi`/`i_mul_lo` is valid.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_op_valid  in  1  operation request from EX.
- i_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored.
- i_rs_data, i_rt_data  in  32  operands.
- i_flush  in  1  kill any in-flight operation (exception).
- i_mfhi_req, i_mflo_req  in  1  HI/LO read request from EX.
- o_busy  out  1  unit cannot accept an operation; HI/LO result pending.
- o_read_stall  out  1  = (i_mfhi_req | i_mflo_req) & o_busy.
- o_hi, o_lo  out  32  architectural HI/LO.
- o_mul_start  out  1  one-cycle start pulse to the multiplier.
- o_mul_a, o_mul_b  out  32  operand magnitudes.
- o_mul_neg  out  1  result negate flag (the multiplier's result_need_process).
- i_mul_hi, i_mul_lo  in  32  final signed product.
- o_div_start, o_div_abort  out  1  one-cycle pulses.
- o_div_dividend, o_div_divisor  out  32  magnitudes.
- i_div_done  in  1  one-cycle done pulse.
- i_div_quot, i_div_rem  in  32  unsigned quotient/remainder.

## Operation
- Accept: `i_op_valid & ~o_busy & ~i_flush` at a rising edge; invalid `i_op` codes are dropped.
- MTHI/MTLO: HI/LO written at the accept edge. State stays IDLE.
- MULT/MULTU:
  - At the accept edge, register `o_mul_a`/`o_mul_b`:
    - MULTU: raw operands.
    - MULT: two's-complement magnitudes, with 0x80000000 staying 0x80000000.
  - `o_mul_neg` = signed & (rs[31] ^ rt[31]).
  - `o_mul_start` = 1 for one cycle; go to MUL_WAIT and load a counter with MULT_LATENCY.
  - The controller performs no post-negation on the product.
- DIV/DIVU with rt ≠ 0:
  - Register dividend/divisor magnitudes (DIVU: raw).
  - Latch q_neg = signed & (rs[31] ^ rt[31]) and r_neg = signed & rs[31].
  - Pulse `o_div_start`; go to DIV_WAIT.
  - On `i_div_done`: LO = q_neg ? −quot : quot; HI = r_neg ? −rem : rem; then return to IDLE.
- DIV/DIVU with rt = 0:
  - Divider not started; `o_div_start` never pulses.
  - Go to DZ for one cycle, then HI = rs, LO = 0xFFFFFFFF, then IDLE.
- States:
  - IDLE→MUL_WAIT|DIV_WAIT|DZ on accept.
  - MUL_WAIT: the counter decrements each cycle. At the edge ending the cycle where the count = 1, capture HI = `i_mul_hi`, LO = `i_mul_lo`, then go to IDLE.
  - DIV_WAIT→IDLE on `i_div_done`.
  - DZ→IDLE unconditionally.
- `o_busy` = state ≠ IDLE (registered-state decode).
- Flush:
  - In any non-IDLE state, the next state is IDLE and there is no HI/LO write.
  - In DIV_WAIT, `o_div_abort` pulses in the cycle following the flush.
  - An `i_div_done` in the same cycle as `i_flush` is discarded.
  - A flush that coincides with `i_op_valid` blocks acceptance.

## Timing
- Reset: state IDLE; `o_hi` = `o_lo` = 0; counter 0; all `o_mul_*`/`o_div_*` = 0; `o_busy` = 0.
- MULT, default latency:
  - accept edge e0;
  - `o_mul_start` in cycle 1;
  - `o_busy` in cycles 1–2;
  - HI/LO written at the end of cycle 2 and visible in cycle 3;
  - `o_busy` = 0 in cycle 3.
  - Generally, HI/LO are visible MULT_LATENCY+1 cycles after the accept edge.
- DIV: `o_div_start` in cycle 1. HI/LO are visible in the cycle after the one with `i_div_done`.
- Divide by zero: `o_busy` in cycle 1 only; HI/LO visible in cycle 2.
- MTHI/MTLO: visible in the cycle after accept.
- Back-to-back: an op presented in the completion cycle sees `o_busy` = 1 and is accepted one cycle later.
- Reads:
  - `o_read_stall` is combinational.
  - A read in the first cycle with `o_busy` = 0 sees the new HI/LO without stall.
- Reset asserted mid-operation: immediate return to reset values. Divider-side cleanup is the divider's own reset.

## Structure
- `mdu_pkg` holds:
  - op encodings (`MDU_MULT`…`MDU_MTLO`);
  - state enum (IDLE, MUL_WAIT, DIV_WAIT, DZ);
  - the divide-by-zero LO constant 0xFFFFFFFF.
- One combinational sub-module, `mdu_abs_neg`, is used four times (operand magnitude and conditional result negation): 32-bit in, enable, 32-bit out.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3:
  - `o_mul_a`=2, `o_mul_b`=3, `o_mul_neg`=1, `o_mul_start` in cycle 1.
  - The bench multiplier model returns the signed product, so HI=0xFFFFFFFF, LO=0xFFFFFFFA in cycle 3.
  - `o_busy` = 1 in cycles 1–2.
- DIV rs=0xFFFFFFF9 (−7), rt=2:
  - dividend=7, divisor=2.
  - Model returns quot=3, rem=1 with done in cycle 34.
  - LO=0xFFFFFFFD and HI=0xFFFFFFFF in cycle 35.
- DIVU rs=5, rt=0: no `o_div_start`; HI=5, LO=0xFFFFFFFF in cycle 2.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with `i_mfhi_req` held:
  - `o_read_stall` = 1 in cycles 1–2 and 0 in cycle 3.
  - HI=0xFFFFFFFE, LO=0x00000001.
- Flush in DIV_WAIT at cycle 5, with `i_div_done` also at cycle 5:
  - HI/LO unchanged and `o_div_abort` pulses in cycle 6.
  - `o_busy` = 0 from cycle 6; an MTLO 0x1234 presented in cycle 6 gives LO=0x1234 in cycle 7.
- `rst_n` low during MUL_WAIT after MTHI 0xAAAA: `o_hi` = `o_lo` = 0 and `o_busy` = 0 immediately (asynchronous); the later multiplier result is ignored.
